// File: rtl/denormalizer_pkg.sv
// Shared FPU constants and types for the denormalizer pipeline.
// Also provides the saturating shift-count helper used by stage 1.
package denormalizer_pkg;

    localparam int EXPONENT_WIDTH   = 10;
    localparam int FRACTION_WIDTH   = 49;
    localparam int MAX_DENORM_SHIFT = 49;
    localparam int SHIFT_WIDTH      = 6;

    typedef logic [EXPONENT_WIDTH-1:0] exponent_t;
    typedef logic [EXPONENT_WIDTH:0]   wide_shift_t;
    typedef logic [FRACTION_WIDTH-1:0] fraction_t;
    typedef logic [SHIFT_WIDTH-1:0]    shift_t;

    typedef struct packed {
        exponent_t exponent;
        fraction_t fraction;
        logic      sticky;
        logic      denorm;
        shift_t    shift;
    } stage1_t;

    // 1 - exponent spans 1..513 for exponent <= 0; anything past a full
    // shift-out behaves identically, so clamp to MAX_DENORM_SHIFT.
    function automatic shift_t sat_shift(input exponent_t exponent);
        wide_shift_t full;
        full = wide_shift_t'(1) - {exponent[EXPONENT_WIDTH-1], exponent};
        if (full >= wide_shift_t'(MAX_DENORM_SHIFT)) begin
            return shift_t'(MAX_DENORM_SHIFT);
        end
        return full[SHIFT_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/denormalizer_right_shifter.sv
// Combinational logical right shifter that also reports whether any 1 bit
// fell off the bottom. A count of 49 shifts everything out.
module denormalizer_right_shifter
    import denormalizer_pkg::*;
(
    input  logic [SHIFT_WIDTH-1:0]    shift_count,
    input  logic [FRACTION_WIDTH-1:0] operand,
    output logic [FRACTION_WIDTH-1:0] result,
    output logic                      shifted_out_sticky
);

    localparam fraction_t ALL_ONES = '1;

    assign result = operand >> shift_count;
    // Bits below the shift point are exactly the ones that leave.
    assign shifted_out_sticky = |(operand & ~(ALL_ONES << shift_count));

endmodule

// File: rtl/denormalizer.sv
// Two-stage denormalizer: stage 1 captures the operand and shift decision,
// stage 2 captures the shifted result presented on the outputs.
module denormalizer
    import denormalizer_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      denormalize,
    input  logic [EXPONENT_WIDTH-1:0] normalized_exponent,
    input  logic [FRACTION_WIDTH-1:0] normalized_fraction,
    input  logic                      sticky_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXPONENT_WIDTH-1:0] denormalized_exponent,
    output logic [FRACTION_WIDTH-1:0] denormalized_fraction,
    output logic                      sticky_out
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both 1; a stage loads when it is empty or the stage after it advances,
    // and stage 2 holds its data unchanged while out_valid=1 and out_ready=0.

    stage1_t   s1_q, s1_d;
    logic      s1_valid_q, s1_valid_d;
    logic      s2_valid_q, s2_valid_d;
    exponent_t s2_exponent_q, s2_exponent_d;
    fraction_t s2_fraction_q, s2_fraction_d;
    logic      s2_sticky_q, s2_sticky_d;

    logic      s1_advance;
    logic      exponent_nonpositive;
    fraction_t shifted_fraction;
    logic      shifted_sticky;

    denormalizer_right_shifter u_shifter (
        .shift_count        (s1_q.shift),
        .operand            (s1_q.fraction),
        .result             (shifted_fraction),
        .shifted_out_sticky (shifted_sticky)
    );

    assign exponent_nonpositive = normalized_exponent[EXPONENT_WIDTH-1]
                                  || (normalized_exponent == '0);

    always_comb begin
        s1_advance    = !s2_valid_q || out_ready;
        in_ready      = !s1_valid_q || s1_advance;
        s1_d          = s1_q;
        s1_valid_d    = s1_valid_q;
        s2_valid_d    = s2_valid_q;
        s2_exponent_d = s2_exponent_q;
        s2_fraction_d = s2_fraction_q;
        s2_sticky_d   = s2_sticky_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_d.exponent = normalized_exponent;
                s1_d.fraction = normalized_fraction;
                s1_d.sticky   = sticky_in;
                s1_d.denorm   = denormalize && exponent_nonpositive;
                s1_d.shift    = sat_shift(normalized_exponent);
            end
        end

        if (s1_advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                if (s1_q.denorm) begin
                    s2_exponent_d = '0;
                    s2_fraction_d = shifted_fraction;
                    s2_sticky_d   = s1_q.sticky || shifted_sticky;
                end else begin
                    s2_exponent_d = s1_q.exponent;
                    s2_fraction_d = s1_q.fraction;
                    s2_sticky_d   = s1_q.sticky;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q          <= '0;
            s1_valid_q    <= 1'b0;
            s2_valid_q    <= 1'b0;
            s2_exponent_q <= '0;
            s2_fraction_q <= '0;
            s2_sticky_q   <= 1'b0;
        end else begin
            s1_q          <= s1_d;
            s1_valid_q    <= s1_valid_d;
            s2_valid_q    <= s2_valid_d;
            s2_exponent_q <= s2_exponent_d;
            s2_fraction_q <= s2_fraction_d;
            s2_sticky_q   <= s2_sticky_d;
        end
    end

    assign out_valid             = s2_valid_q;
    assign denormalized_exponent = s2_exponent_q;
    assign denormalized_fraction = s2_fraction_q;
    assign sticky_out            = s2_sticky_q;

endmodule

// File: tb/tb_denormalizer.sv
// Directed bench for the denormalizer: vector table with latency checks,
// backpressure, streaming with stalls, and reset with operands in flight.
module tb_denormalizer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        denormalize;
    logic [9:0]  normalized_exponent;
    logic [48:0] normalized_fraction;
    logic        sticky_in;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  denormalized_exponent;
    logic [48:0] denormalized_fraction;
    logic        sticky_out;

    typedef logic [59:0] res_t;

    typedef struct {
        logic [9:0]  exp_in;
        logic [48:0] frac_in;
        logic        den;
        logic        st_in;
        logic [9:0]  exp_out;
        logic [48:0] frac_out;
        logic        st_out;
    } vec_t;

    localparam int NVEC = 15;
    vec_t tbl[NVEC];
    res_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    denormalizer dut (
        .clk                   (clk),
        .reset                 (reset),
        .in_valid              (in_valid),
        .in_ready              (in_ready),
        .denormalize           (denormalize),
        .normalized_exponent   (normalized_exponent),
        .normalized_fraction   (normalized_fraction),
        .sticky_in             (sticky_in),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .denormalized_exponent (denormalized_exponent),
        .denormalized_fraction (denormalized_fraction),
        .sticky_out            (sticky_out)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic res_t expected(input vec_t v);
        return {v.exp_out, v.frac_out, v.st_out};
    endfunction

    // One clock cycle: drive at negedge, evaluate handshakes, run scoreboard.
    task automatic step(input logic iv, input vec_t v, input logic ordy, input logic rst,
                        output logic acc, output logic dlv, output logic ov,
                        output logic irdy, output res_t snap);
        @(negedge clk);
        reset               = rst;
        in_valid            = iv;
        normalized_exponent = v.exp_in;
        normalized_fraction = v.frac_in;
        denormalize         = v.den;
        sticky_in           = v.st_in;
        out_ready           = ordy;
        #1;
        irdy = in_ready;
        ov   = out_valid;
        snap = {denormalized_exponent, denormalized_fraction, sticky_out};
        acc  = iv && in_ready && !rst;
        dlv  = (out_valid === 1'b1) && ordy && !rst;
        if (dlv) begin
            if (exp_q.size() == 0) check("unexpected_output", 64'd1, 64'd0);
            else check("result", 64'(snap), 64'(exp_q.pop_front()));
        end
        if (acc) exp_q.push_back(expected(v));
        @(posedge clk);
    endtask

    initial begin
        logic acc, dlv, ov, irdy;
        res_t snap;
        int   idx;

        reset = 1'b1; in_valid = 1'b0; denormalize = 1'b0; normalized_exponent = '0;
        normalized_fraction = '0; sticky_in = 1'b0; out_ready = 1'b0;

        tbl[0]  = '{10'h3FE, 49'h0800000000000, 1'b1, 1'b0, 10'h000, 49'h0100000000000, 1'b0};
        tbl[1]  = '{10'h000, 49'h0800000000001, 1'b1, 1'b0, 10'h000, 49'h0400000000000, 1'b1};
        tbl[2]  = '{10'h39C, 49'h0C00000000000, 1'b1, 1'b0, 10'h000, 49'h0000000000000, 1'b1};
        tbl[3]  = '{10'h005, 49'h0C00000000000, 1'b1, 1'b1, 10'h005, 49'h0C00000000000, 1'b1};
        tbl[4]  = '{10'h3FD, 49'h0C00000000000, 1'b0, 1'b0, 10'h3FD, 49'h0C00000000000, 1'b0};
        tbl[5]  = '{10'h200, 49'h0000000000000, 1'b1, 1'b1, 10'h000, 49'h0000000000000, 1'b1};
        tbl[6]  = '{10'h200, 49'h0000000000000, 1'b1, 1'b0, 10'h000, 49'h0000000000000, 1'b0};
        tbl[7]  = '{10'h3D1, 49'h1000000000000, 1'b1, 1'b0, 10'h000, 49'h0000000000001, 1'b0};
        tbl[8]  = '{10'h3D0, 49'h1000000000000, 1'b1, 1'b0, 10'h000, 49'h0000000000000, 1'b1};
        tbl[9]  = '{10'h3D0, 49'h0000000000001, 1'b1, 1'b0, 10'h000, 49'h0000000000000, 1'b1};
        tbl[10] = '{10'h001, 49'h0000000001234, 1'b1, 1'b0, 10'h001, 49'h0000000001234, 1'b0};
        tbl[11] = '{10'h3FF, 49'h1FFFFFFFFFFFF, 1'b1, 1'b0, 10'h000, 49'h07FFFFFFFFFFF, 1'b1};
        tbl[12] = '{10'h1FF, 49'h1FFFFFFFFFFFF, 1'b1, 1'b0, 10'h1FF, 49'h1FFFFFFFFFFFF, 1'b0};
        tbl[13] = '{10'h201, 49'h1000000000000, 1'b1, 1'b0, 10'h000, 49'h0000000000000, 1'b1};
        tbl[14] = '{10'h000, 49'h0000000000003, 1'b1, 1'b0, 10'h000, 49'h0000000000001, 1'b1};

        // Reset with in_valid asserted; nothing may be captured.
        for (int i = 0; i < 3; i++) step(1'b1, tbl[0], 1'b0, 1'b1, acc, dlv, ov, irdy, snap);
        step(1'b0, tbl[0], 1'b1, 1'b0, acc, dlv, ov, irdy, snap);
        check("reset_out_valid", 64'(ov), 64'd0);
        check("reset_in_ready", 64'(irdy), 64'd1);
        check("reset_outputs", 64'(snap), 64'd0);
        step(1'b0, tbl[0], 1'b1, 1'b0, acc, dlv, ov, irdy, snap);
        check("reset_no_ghost", 64'(ov), 64'd0);

        // Table: one operand at a time, result must appear exactly 2 cycles on.
        for (int i = 0; i < NVEC; i++) begin
            step(1'b1, tbl[i], 1'b1, 1'b0, acc, dlv, ov, irdy, snap);
            check($sformatf("vec%0d_accept", i), 64'(acc), 64'd1);
            step(1'b0, tbl[i], 1'b1, 1'b0, acc, dlv, ov, irdy, snap);
            check($sformatf("vec%0d_lat1", i), 64'(ov), 64'd0);
            step(1'b0, tbl[i], 1'b1, 1'b0, acc, dlv, ov, irdy, snap);
            check($sformatf("vec%0d_lat2", i), 64'(ov), 64'd1);
            check($sformatf("vec%0d_drained", i), 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end

        // Backpressure: 4 back-to-back operands, downstream stalled 6 cycles.
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            step(idx < 4, tbl[idx < 4 ? idx : 0], c >= 6, 1'b0, acc, dlv, ov, irdy, snap);
            if (acc) idx++;
            if (c >= 2 && c <= 5) begin
                check($sformatf("bp_in_ready_c%0d", c), 64'(irdy), 64'd0);
                check($sformatf("bp_out_valid_c%0d", c), 64'(ov), 64'd1);
                check($sformatf("bp_hold_c%0d", c), 64'(snap), 64'(expected(tbl[0])));
            end
            if (c >= 6) check($sformatf("bp_deliver_c%0d", c), 64'(dlv), 64'(c <= 9));
        end
        check("bp_all_accepted", 64'(idx), 64'd4);
        check("bp_queue_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();

        // Streaming the whole table with a periodic downstream stall.
        idx = 0;
        for (int c = 0; c < 80 && (idx < NVEC || exp_q.size() != 0); c++) begin
            step(idx < NVEC, tbl[idx < NVEC ? idx : 0], (c % 3) != 2, 1'b0, acc, dlv, ov, irdy, snap);
            if (acc) idx++;
        end
        check("stream_all_accepted", 64'(idx), 64'(NVEC));
        check("stream_queue_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();

        // Reset with two operands in flight: both must vanish.
        step(1'b1, tbl[4], 1'b0, 1'b0, acc, dlv, ov, irdy, snap);
        step(1'b1, tbl[5], 1'b0, 1'b0, acc, dlv, ov, irdy, snap);
        step(1'b1, tbl[6], 1'b0, 1'b1, acc, dlv, ov, irdy, snap);
        exp_q.delete();
        step(1'b0, tbl[0], 1'b1, 1'b0, acc, dlv, ov, irdy, snap);
        check("mid_reset_out_valid", 64'(ov), 64'd0);
        check("mid_reset_in_ready", 64'(irdy), 64'd1);
        check("mid_reset_outputs", 64'(snap), 64'd0);
        for (int c = 0; c < 5; c++) begin
            step(1'b0, tbl[0], 1'b1, 1'b0, acc, dlv, ov, irdy, snap);
            check($sformatf("mid_reset_quiet_c%0d", c), 64'(ov), 64'd0);
        end

        // Pipeline still works after the mid-operation reset.
        step(1'b1, tbl[1], 1'b1, 1'b0, acc, dlv, ov, irdy, snap);
        for (int c = 0; c < 4; c++) step(1'b0, tbl[1], 1'b1, 1'b0, acc, dlv, ov, irdy, snap);
        check("post_reset_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/denormalizer.md
DENORMALIZER -- requirements
Module: denormalizer

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: an input operand is presented.
REQ-004 SHALL have port in_ready, output, 1 bit: the block accepts an operand this cycle.
REQ-005 SHALL have port denormalize, input, 1 bit: denormalization is enabled for this operand.
REQ-006 SHALL have port normalized_exponent, input, 10 bits: two's-complement biased exponent.
REQ-007 SHALL have port normalized_fraction, input, 49 bits: [xx.xxxx...] format, 2 integer bits and 47 fraction bits.
REQ-008 SHALL have port sticky_in, input, 1 bit: sticky bit from upstream.
REQ-009 SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 SHALL have port denormalized_exponent, output, 10 bits: result exponent.
REQ-012 SHALL have port denormalized_fraction, output, 49 bits: result fraction, same format as the input.
REQ-013 SHALL have port sticky_out, output, 1 bit: sticky_in OR all bits shifted out.

Function
REQ-014 SHALL accept an operand on any cycle where in_valid and in_ready are both 1.
REQ-015 SHALL deliver a result on any cycle where out_valid and out_ready are both 1.
REQ-016 SHALL be a 2-stage pipeline with no bubbles.
  - Stage 1 registers the operand, the denorm flag and the shift count.
  - Stage 2 registers the shifted result.
  - Latency from accept to out_valid is 2 cycles.
REQ-017 SHALL advance each stage when that stage is empty or the stage after it advances.
  - in_ready = !s1_valid || s1_advance, where s1_advance = !s2_valid || out_ready.
  - Full throughput is 1 operand per cycle.
REQ-018 SHALL hold out_valid and all output data stable while out_valid=1 and out_ready=0.
REQ-019 SHALL denormalize only when denormalize=1 AND normalized_exponent <= 0 (signed). In that case:
  - shift = 1 - exponent, range 1..513;
  - denormalized_exponent = 0;
  - fraction is logically right-shifted by the shift amount;
  - sticky_out = sticky_in OR (any 1 bit shifted out).
REQ-020 SHALL treat any shift >= 49 as a full shift-out.
  - denormalized_fraction = 0.
  - sticky_out = sticky_in OR (OR of all 49 input bits).
  - The shift count is saturated to 6 bits (49) in stage 1.
REQ-021 SHALL otherwise pass exponent and fraction through unchanged, with sticky_out = sticky_in.
REQ-022 SHALL produce an all-zero fraction input with sticky_out = sticky_in, whatever the shift.
REQ-023 SHALL preserve result order; no reordering, drop or duplication under any in_valid/out_ready pattern.

Reset
REQ-024 SHALL, when reset=1 at a clock edge:
  - clear both stage valid bits, so out_valid=0 the next cycle;
  - drive denormalized_exponent=0, denormalized_fraction=0, sticky_out=0.
REQ-025 SHALL discard all in-flight operands on reset mid-operation.
REQ-026 SHALL drive in_ready=1 in the first cycle after reset deasserts.
REQ-027 SHALL ignore in_valid while reset=1.

Structure
REQ-028 SHALL place these constants in the shared FPU package:
  - EXPONENT_WIDTH=10;
  - FRACTION_WIDTH=49;
  - MAX_DENORM_SHIFT=49.
REQ-029 SHALL instantiate one sub-module, denormalizer_right_shifter.
  - It is combinational.
  - Inputs: 6-bit shift_count and 49-bit operand.
  - Outputs: 49-bit result and shifted_out_sticky.
  - It sits between stage 1 and stage 2.

Verification
REQ-030 SHALL cover: exponent=-2, fraction=49'h0800000000000 (1.0), denormalize=1, sticky_in=0 -> 2 cycles later exponent=0, fraction=49'h0100000000000, sticky_out=0.
REQ-031 SHALL cover: exponent=0, fraction=49'h0800000000001, denormalize=1 -> exponent=0, fraction=49'h0400000000000, sticky_out=1.
REQ-032 SHALL cover: exponent=-100, fraction=49'h0C00000000000 -> fraction=0, exponent=0, sticky_out=1; and exponent=5 or denormalize=0 -> unchanged passthrough, sticky_out=sticky_in.
REQ-033 SHALL cover backpressure: send 4 back-to-back operands with out_ready=0 -> in_ready=0 once both stages are full, outputs held stable; then out_ready=1 -> all 4 results emerge in order, one per cycle.
REQ-034 SHALL cover reset mid-operation: reset with 2 operands in flight -> out_valid=0 next cycle, neither operand ever appears, in_ready=1 after release.
